// File: rtl/rf_pkg.sv
// Shared defaults and helpers for the multi-port register file and its scoreboard.
package rf_pkg;

  localparam int unsigned RF_XLEN_DEF  = 32;
  localparam int unsigned RF_NREGS_DEF = 32;
  localparam int unsigned RF_ZERO_IDX  = 0;

  // Low bit of port 'port' inside a packed multi-port bus of 'width'-bit lanes.
  function automatic int unsigned port_lo(input int unsigned port, input int unsigned width);
    return port * width;
  endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// Decode/writeback bus of the multi-port register file: reads, writes and destination claims.
interface regfile_mp_if
  import rf_pkg::*;
#(
  parameter int unsigned XLEN  = RF_XLEN_DEF,
  parameter int unsigned NREGS = RF_NREGS_DEF,
  parameter int unsigned NRP   = 2,
  parameter int unsigned NWP   = 1
);
  localparam int unsigned AW = $clog2(NREGS);

  logic [NRP*AW-1:0]   rs_addr;
  logic [NRP*XLEN-1:0] rs_data;
  logic [NRP-1:0]      rs_busy;
  logic [NWP-1:0]      wr_en;
  logic [NWP*AW-1:0]   wr_addr;
  logic [NWP*XLEN-1:0] wr_data;
  logic                claim_en;
  logic [AW-1:0]       claim_addr;
  logic                claim_err;

  modport master (
    output rs_addr, wr_en, wr_addr, wr_data, claim_en, claim_addr,
    input  rs_data, rs_busy, claim_err
  );

  modport slave (
    input  rs_addr, wr_en, wr_addr, wr_data, claim_en, claim_addr,
    output rs_data, rs_busy, claim_err
  );

endinterface

// File: rtl/rf_scoreboard.sv
// Per-register busy tracking: decode claims set, writeback releases, and a pulse on WAW claims.
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int unsigned NREGS     = RF_NREGS_DEF,
  parameter int unsigned NWP       = 1,
  parameter bit          ZERO_REG0 = 1'b1,
  parameter int unsigned AW        = $clog2(NREGS)
)(
  input  logic              clk,
  input  logic              rst,
  input  logic              claim_en_i,
  input  logic [AW-1:0]     claim_addr_i,
  input  logic [NWP-1:0]    wr_en_i,
  input  logic [NWP*AW-1:0] wr_addr_i,
  output logic [NREGS-1:0]  busy_o,
  output logic              claim_err_o
);

  localparam logic [AW-1:0] ZERO_ADDR = AW'(RF_ZERO_IDX);

  logic [NREGS-1:0] busy_q, busy_d;
  logic             claim_err_q, claim_err_d;
  logic             claim_ok;
  logic             claim_hit_wr;

  always_comb begin
    claim_ok     = claim_en_i && !(ZERO_REG0 && (claim_addr_i == ZERO_ADDR));
    claim_hit_wr = 1'b0;
    busy_d       = busy_q;
    for (int w = 0; w < NWP; w++) begin
      if (wr_en_i[w]) begin
        busy_d[wr_addr_i[port_lo(w, AW) +: AW]] = 1'b0;
        if (wr_addr_i[port_lo(w, AW) +: AW] == claim_addr_i) claim_hit_wr = 1'b1;
      end
    end
    // Claim is applied last so it overrides a same-edge release.
    if (claim_ok) busy_d[claim_addr_i] = 1'b1;
    claim_err_d = claim_ok && busy_q[claim_addr_i] && !claim_hit_wr;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q      <= '0;
      claim_err_q <= 1'b0;
    end else begin
      busy_q      <= busy_d;
      claim_err_q <= claim_err_d;
    end
  end

  assign busy_o      = busy_q;
  assign claim_err_o = claim_err_q;

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-port integer register file with optional write-to-read bypass and busy scoreboard.
module regfile_mp
  import rf_pkg::*;
#(
  parameter int unsigned XLEN      = RF_XLEN_DEF,
  parameter int unsigned NREGS     = RF_NREGS_DEF,
  parameter int unsigned NRP       = 2,
  parameter int unsigned NWP       = 1,
  parameter bit          BYPASS    = 1'b1,
  parameter bit          ZERO_REG0 = 1'b1
)(
  input  logic         clk,
  input  logic         rst,
  regfile_mp_if.slave  rf_bus
);

  localparam int unsigned   AW        = $clog2(NREGS);
  localparam logic [AW-1:0] ZERO_ADDR = AW'(RF_ZERO_IDX);

  logic [XLEN-1:0]  mem_q [NREGS];
  logic [XLEN-1:0]  mem_d [NREGS];
  logic [NREGS-1:0] busy;

  logic [AW-1:0]    rs_addr_a [NRP];
  logic [AW-1:0]    wr_addr_a [NWP];
  logic [XLEN-1:0]  wr_data_a [NWP];
  logic [XLEN-1:0]  rd_data   [NRP];
  logic             rd_busy   [NRP];

  always_comb begin
    for (int p = 0; p < NRP; p++) rs_addr_a[p] = rf_bus.rs_addr[port_lo(p, AW) +: AW];
    for (int w = 0; w < NWP; w++) begin
      wr_addr_a[w] = rf_bus.wr_addr[port_lo(w, AW) +: AW];
      wr_data_a[w] = rf_bus.wr_data[port_lo(w, XLEN) +: XLEN];
    end
  end

  rf_scoreboard #(
    .NREGS     (NREGS),
    .NWP       (NWP),
    .ZERO_REG0 (ZERO_REG0),
    .AW        (AW)
  ) u_sb (
    .clk          (clk),
    .rst          (rst),
    .claim_en_i   (rf_bus.claim_en),
    .claim_addr_i (rf_bus.claim_addr),
    .wr_en_i      (rf_bus.wr_en),
    .wr_addr_i    (rf_bus.wr_addr),
    .busy_o       (busy),
    .claim_err_o  (rf_bus.claim_err)
  );

  // Ports are applied in ascending order so the highest-index port wins a collision.
  always_comb begin
    for (int r = 0; r < NREGS; r++) mem_d[r] = mem_q[r];
    for (int w = 0; w < NWP; w++) begin
      if (rf_bus.wr_en[w] && !(ZERO_REG0 && (wr_addr_a[w] == ZERO_ADDR)))
        mem_d[wr_addr_a[w]] = wr_data_a[w];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NREGS; r++) mem_q[r] <= '0;
    end else begin
      for (int r = 0; r < NREGS; r++) mem_q[r] <= mem_d[r];
    end
  end

  always_comb begin
    for (int p = 0; p < NRP; p++) begin
      rd_data[p] = mem_q[rs_addr_a[p]];
      rd_busy[p] = busy[rs_addr_a[p]];
      if (BYPASS) begin
        for (int w = 0; w < NWP; w++) begin
          if (rf_bus.wr_en[w] && (wr_addr_a[w] == rs_addr_a[p])) begin
            rd_data[p] = wr_data_a[w];
            rd_busy[p] = 1'b0;
          end
        end
      end
      if (ZERO_REG0 && (rs_addr_a[p] == ZERO_ADDR)) rd_data[p] = '0;
    end
  end

  for (genvar p = 0; p < NRP; p++) begin : g_rd
    assign rf_bus.rs_data[p*XLEN +: XLEN] = rd_data[p];
    assign rf_bus.rs_busy[p]              = rd_busy[p];
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench: two register files (dual-write with bypass, single-write without) driven in lockstep.
module tb_regfile_mp;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  regfile_mp_if #(.XLEN(32), .NREGS(32), .NRP(2), .NWP(2)) bus_a ();
  regfile_mp_if #(.XLEN(32), .NREGS(32), .NRP(2), .NWP(1)) bus_b ();

  regfile_mp #(.XLEN(32), .NREGS(32), .NRP(2), .NWP(2), .BYPASS(1'b1), .ZERO_REG0(1'b1)) u_dut_a (
    .clk    (clk),
    .rst    (rst),
    .rf_bus (bus_a)
  );

  regfile_mp #(.XLEN(32), .NREGS(32), .NRP(2), .NWP(1), .BYPASS(1'b0), .ZERO_REG0(1'b1)) u_dut_b (
    .clk    (clk),
    .rst    (rst),
    .rf_bus (bus_b)
  );

  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] val;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  logic [31:0] mdl_a [32];
  logic [31:0] mdl_b [32];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    if (obs !== expv) begin
      n_miss++;
      $display("FAIL %s: observed %08h expected %08h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] observe(input int sel);
    case (sel)
      0:       return bus_a.rs_data[31:0];
      1:       return bus_a.rs_data[63:32];
      2:       return {31'b0, bus_a.rs_busy[0]};
      3:       return {31'b0, bus_a.rs_busy[1]};
      4:       return {31'b0, bus_a.claim_err};
      5:       return bus_b.rs_data[31:0];
      6:       return bus_b.rs_data[63:32];
      7:       return {31'b0, bus_b.rs_busy[0]};
      8:       return {31'b0, bus_b.rs_busy[1]};
      9:       return {31'b0, bus_b.claim_err};
      default: return 'x;
    endcase
  endfunction

  task automatic push(input string tag, input int sel, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.val = val;
    exp_q.push_back(e);
  endtask

  task automatic drain();
    while (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk(e.tag, observe(e.sel), e.val);
    end
  endtask

  task automatic exp_rd(input string tag, input int p, input logic [31:0] va, input logic [31:0] vb);
    push({tag, "_a"}, p, va);
    push({tag, "_b"}, 5 + p, vb);
  endtask

  task automatic exp_busy(input string tag, input int p, input logic ba, input logic bb);
    push({tag, "_a"}, 2 + p, {31'b0, ba});
    push({tag, "_b"}, 7 + p, {31'b0, bb});
  endtask

  task automatic exp_err(input string tag, input logic ea, input logic eb);
    push({tag, "_a"}, 4, {31'b0, ea});
    push({tag, "_b"}, 9, {31'b0, eb});
  endtask

  task automatic idle();
    bus_a.wr_en = '0; bus_a.wr_addr = '0; bus_a.wr_data = '0;
    bus_a.claim_en = 1'b0; bus_a.claim_addr = '0;
    bus_b.wr_en = '0; bus_b.wr_addr = '0; bus_b.wr_data = '0;
    bus_b.claim_en = 1'b0; bus_b.claim_addr = '0;
  endtask

  task automatic wr0(input logic [4:0] a, input logic [31:0] d);
    bus_a.wr_en[0] = 1'b1; bus_a.wr_addr[4:0] = a; bus_a.wr_data[31:0] = d;
    bus_b.wr_en[0] = 1'b1; bus_b.wr_addr[4:0] = a; bus_b.wr_data[31:0] = d;
  endtask

  task automatic wr1_a(input logic [4:0] a, input logic [31:0] d);
    bus_a.wr_en[1] = 1'b1; bus_a.wr_addr[9:5] = a; bus_a.wr_data[63:32] = d;
  endtask

  task automatic rd(input int p, input logic [4:0] a);
    if (p == 0) begin
      bus_a.rs_addr[4:0] = a; bus_b.rs_addr[4:0] = a;
    end else begin
      bus_a.rs_addr[9:5] = a; bus_b.rs_addr[9:5] = a;
    end
  endtask

  task automatic claim(input logic [4:0] a);
    bus_a.claim_en = 1'b1; bus_a.claim_addr = a;
    bus_b.claim_en = 1'b1; bus_b.claim_addr = a;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic sample();
    @(negedge clk);
    drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    bus_a.rs_addr = '0;
    bus_b.rs_addr = '0;
    idle();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    exp_rd("rst_rd", 0, 32'h0, 32'h0);
    exp_busy("rst_busy", 0, 1'b0, 1'b0);
    exp_err("rst_err", 1'b0, 1'b0);
    drain();

    next_cycle(); wr0(5'd5, 32'hDEADBEEF); rd(0, 5'd5); rd(1, 5'd5);
    exp_rd("wr5_same_p0", 0, 32'hDEADBEEF, 32'h0);
    exp_rd("wr5_same_p1", 1, 32'hDEADBEEF, 32'h0);
    sample();
    next_cycle();
    exp_rd("rd5_p0", 0, 32'hDEADBEEF, 32'hDEADBEEF);
    exp_rd("rd5_p1", 1, 32'hDEADBEEF, 32'hDEADBEEF);
    sample();

    next_cycle(); wr0(5'd0, 32'h1234); rd(0, 5'd0);
    exp_rd("x0_wr_same", 0, 32'h0, 32'h0);
    sample();
    next_cycle();
    exp_rd("x0_rd", 0, 32'h0, 32'h0);
    sample();

    next_cycle(); claim(5'd7); rd(0, 5'd7);
    exp_busy("clm7_same", 0, 1'b0, 1'b0);
    sample();
    next_cycle(); wr0(5'd7, 32'hA5A5A5A5); rd(0, 5'd7);
    exp_rd("byp7_data", 0, 32'hA5A5A5A5, 32'h0);
    exp_busy("byp7_busy", 0, 1'b0, 1'b1);
    sample();
    next_cycle();
    exp_rd("x7_after", 0, 32'hA5A5A5A5, 32'hA5A5A5A5);
    exp_busy("x7_rel", 0, 1'b0, 1'b0);
    sample();

    next_cycle(); wr0(5'd3, 32'h11); wr1_a(5'd3, 32'h22); rd(1, 5'd3);
    exp_rd("dual_byp", 1, 32'h22, 32'h0);
    sample();
    next_cycle();
    exp_rd("dual_rd", 1, 32'h22, 32'h11);
    sample();

    next_cycle(); claim(5'd9); rd(0, 5'd9);
    exp_busy("clm9_same", 0, 1'b0, 1'b0);
    sample();
    next_cycle();
    exp_busy("clm9_next", 0, 1'b1, 1'b1);
    exp_err("clm9_err", 1'b0, 1'b0);
    sample();
    next_cycle(); wr0(5'd9, 32'h99);
    exp_busy("wr9_mask", 0, 1'b0, 1'b1);
    sample();
    next_cycle();
    exp_busy("wr9_rel", 0, 1'b0, 1'b0);
    exp_rd("wr9_data", 0, 32'h99, 32'h99);
    sample();
    next_cycle(); claim(5'd9); wr0(5'd9, 32'h98);
    sample();
    next_cycle();
    exp_busy("clmwr9_busy", 0, 1'b1, 1'b1);
    exp_err("clmwr9_err", 1'b0, 1'b0);
    sample();
    next_cycle(); claim(5'd9); wr0(5'd9, 32'h97);
    sample();
    next_cycle();
    exp_busy("reclm9_busy", 0, 1'b1, 1'b1);
    exp_err("reclm9_err", 1'b0, 1'b0);
    sample();

    next_cycle(); claim(5'd4); rd(1, 5'd4);
    sample();
    next_cycle(); claim(5'd4);
    exp_err("clm4_first", 1'b0, 1'b0);
    exp_busy("clm4_busy", 1, 1'b1, 1'b1);
    sample();
    next_cycle();
    exp_err("clm4_err", 1'b1, 1'b1);
    exp_busy("clm4_keep", 1, 1'b1, 1'b1);
    sample();
    next_cycle();
    exp_err("clm4_pulse", 1'b0, 1'b0);
    sample();
    next_cycle(); claim(5'd0); rd(0, 5'd0);
    sample();
    next_cycle();
    exp_busy("clm0_busy", 0, 1'b0, 1'b0);
    exp_err("clm0_err", 1'b0, 1'b0);
    sample();

    next_cycle(); claim(5'd4); rd(0, 5'd5); rd(1, 5'd4);
    sample();
    next_cycle();
    exp_err("pre_rst_err", 1'b1, 1'b1);
    exp_rd("pre_rst_x5", 0, 32'hDEADBEEF, 32'hDEADBEEF);
    sample();
    #2 rst = 1'b1;
    #1;
    exp_rd("rst_x5", 0, 32'h0, 32'h0);
    exp_busy("rst_busy4", 1, 1'b0, 1'b0);
    exp_err("rst_err_clr", 1'b0, 1'b0);
    drain();
    wr0(5'd5, 32'h77);
    #1 rst = 1'b0;
    next_cycle();
    exp_rd("post_rst_wr", 0, 32'h77, 32'h77);
    sample();

    for (int r = 0; r < 32; r++) begin
      mdl_a[r] = 32'h0;
      mdl_b[r] = 32'h0;
    end
    mdl_a[5] = 32'h77;
    mdl_b[5] = 32'h77;

    for (int i = 0; i < 40; i++) begin
      logic        en0, en1;
      logic [4:0]  a0, a1;
      logic [31:0] d0, d1;
      logic [4:0]  ra [2];
      logic [31:0] ea, eb;
      next_cycle();
      en0 = 1'($urandom_range(0, 1));
      en1 = 1'($urandom_range(0, 1));
      a0  = 5'($urandom_range(0, 7));
      a1  = 5'($urandom_range(0, 7));
      d0  = $urandom;
      d1  = $urandom;
      ra[0] = 5'($urandom_range(0, 7));
      ra[1] = 5'($urandom_range(0, 7));
      if (en0) wr0(a0, d0);
      if (en1) wr1_a(a1, d1);
      rd(0, ra[0]);
      rd(1, ra[1]);
      for (int p = 0; p < 2; p++) begin
        if (ra[p] == 5'd0)            ea = 32'h0;
        else if (en1 && a1 == ra[p])  ea = d1;
        else if (en0 && a0 == ra[p])  ea = d0;
        else                          ea = mdl_a[ra[p]];
        eb = (ra[p] == 5'd0) ? 32'h0 : mdl_b[ra[p]];
        exp_rd($sformatf("rnd%0d_p%0d", i, p), p, ea, eb);
      end
      exp_busy($sformatf("rnd%0d_busy", i), 0, 1'b0, 1'b0);
      sample();
      if (en0 && a0 != 5'd0) begin
        mdl_a[a0] = d0;
        mdl_b[a0] = d0;
      end
      if (en1 && a1 != 5'd0) mdl_a[a1] = d1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised successor of the single-write, two-read integer register file.
- Adds configurable data width, register count, read-port and write-port counts, optional same-cycle write-to-read bypass, asynchronous reset clearing, and a per-register busy scoreboard.
- Sits between decode (reads, busy check, destination claim) and writeback (writes, busy release) of the pipelined core.

Parameters:
- XLEN, 32, data width of each register.
- NREGS, 32, number of registers; power of two, ≥2.
- AW, $clog2(NREGS), address width (derived; not overridden).
- NRP, 2, number of read ports (1..4).
- NWP, 1, number of write ports (1..2).
- BYPASS, 1, 1 = a read returns same-cycle write data; 0 = a read returns the stored value.
- ZERO_REG0, 1, 1 = register 0 reads as zero, ignores writes and is never busy.

Ports:
- clk, input, 1, rising-edge clock.
- rst, input, 1, asynchronous active-high reset.
- rs_addr, input, NRP*AW, read addresses; port p occupies bits [p*AW +: AW].
- rs_data, output, NRP*XLEN, read data; port p occupies bits [p*XLEN +: XLEN].
- rs_busy, output, NRP, scoreboard busy flag for each read address.
- wr_en, input, NWP, per-port write enable.
- wr_addr, input, NWP*AW, write addresses.
- wr_data, input, NWP*XLEN, write data.
- claim_en, input, 1, decode claims a destination register (sets busy).
- claim_addr, input, AW, destination register being claimed.
- claim_err, output, 1, registered flag: an illegal claim was attempted on the previous edge.

Behaviour:
- Reset (async, while rst=1):
  - all registers = 0; all busy bits = 0; claim_err = 0.
  - Combinational outputs follow from the cleared state: rs_data = 0, rs_busy = 0.
  - An assertion mid-cycle discards any pending writes and claims. The first write after reset is accepted on the first rising edge with rst=0.
- Write:
  - On the rising edge, each port with wr_en=1 stores wr_data at wr_addr.
  - If ZERO_REG0=1, writes to address 0 are dropped.
  - Both ports on the same address: port 1 wins.
- Read: combinational, zero latency.
  - BYPASS=0: rs_data is the stored value.
  - BYPASS=1: rs_data is the data of the highest-index enabled write port whose wr_addr matches rs_addr, otherwise the stored value.
  - Address 0 with ZERO_REG0=1 always reads 0, including under bypass.
- Scoreboard: one busy bit per register. On the rising edge:
  - busy[claim_addr] is set when claim_en=1.
  - busy[wr_addr] is cleared for each enabled write port.
  - If a claim and a write hit the same register on the same edge, the claim wins and busy stays 1.
  - Claiming register 0 with ZERO_REG0=1 is ignored.
- rs_busy[p] = busy[rs_addr_p], masked to 0 when BYPASS=1 and an enabled write port targets that address in the same cycle.
  - A same-cycle claim is not visible in rs_busy until the next cycle.
- WAW protection:
  - A claim to an already-busy register that is not being written in the same cycle is illegal.
  - The busy bit stays 1, and claim_err pulses 1 for one cycle after that edge.
  - The issuer must stall instead.
- Registered state: register array, busy vector, claim_err. No other state.

Decomposition:
- Shared package rf_pkg holds the XLEN/NREGS defaults, the zero-register index and the helper function for packed-port slicing.
- Natural sub-module: rf_scoreboard (busy vector, claim/release priority, claim_err). The data array, write logic and bypass muxes stay in the top module.

Test Plan:
- Reset: pulse rst asynchronously between clock edges → every register reads 0, rs_busy = 0 and claim_err = 0 immediately, without waiting for a clock edge.
- Write then read: write 0xDEADBEEF to x5, then read x5 on port 0 and port 1 → both return 0xDEADBEEF. Write 0x1234 to x0 → x0 still reads 0.
- Bypass: BYPASS=1, write 0xA5A5A5A5 to x7 while reading x7 in the same cycle → rs_data = 0xA5A5A5A5 and rs_busy = 0. Repeat with BYPASS=0 → the old value is returned.
- Dual-write collision: NWP=2, both ports write x3 (port 0 = 0x11, port 1 = 0x22) → x3 = 0x22. Bypass in that cycle also shows 0x22.
- Scoreboard: claim x9 → rs_busy = 1 from the next cycle. A write to x9 clears it. A claim and a write to x9 on the same edge → x9 stays busy.
- Illegal claim: claim x4 twice without an intervening write → claim_err = 1 for exactly one cycle and x4 stays busy. Claim x0 → no busy bit set and no error.
